// File: rtl/sa_result_drain_pkg.sv
// Shared constants, state encoding and element-slice helper for the result drain.
// Also used by the wrappers that flatten result1_*/result2_* into the flat buses.
package sa_result_drain_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned BEATS = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StFin   = 2'd2
  } state_e;

  // Bit offset of element k in a flat bus of 2*w-bit elements.
  function automatic int unsigned elem_off(input int unsigned k, input int unsigned w);
    return k * 2 * w;
  endfunction

endpackage

// File: rtl/sa_result_drain_if.sv
// Row-beat stream from the result drain to the writeback/softmax path.
interface sa_result_drain_if #(
  parameter int unsigned width = 8
) ();

  logic                   out_valid;
  logic                   out_ready;
  logic [4*2*width-1:0]   out_data;
  logic                   out_mat;
  logic [1:0]             out_row;
  logic                   out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_mat,
    output out_row,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_mat,
    input  out_row,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sa_row_mux.sv
// Selects one row of one latched 4x4 result matrix; column 0 lands in the lowest bits.
module sa_row_mux
  import sa_result_drain_pkg::elem_off;
#(
  parameter int unsigned width = 8,
  parameter int unsigned ROWS  = 4
) (
  input  logic [ROWS*ROWS*2*width-1:0] res1_i,
  input  logic [ROWS*ROWS*2*width-1:0] res2_i,
  input  logic                         mat_i,
  input  logic [1:0]                   row_i,
  output logic [ROWS*2*width-1:0]      row_o
);

  localparam int unsigned EW = 2 * width;

  always_comb begin
    row_o = '0;
    for (int unsigned c = 0; c < ROWS; c++) begin
      if (mat_i) begin
        row_o[c*EW +: EW] = res2_i[elem_off(32'(row_i) * ROWS + c, width) +: EW];
      end else begin
        row_o[c*EW +: EW] = res1_i[elem_off(32'(row_i) * ROWS + c, width) +: EW];
      end
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Captures both result matrices on a capture pulse and streams them out one row per beat,
// suppressing the stream entirely when the head is pruned.
module sa_result_drain #(
  parameter int unsigned width = 8,
  parameter int unsigned ROWS  = 4
) (
  input  logic                    clk,
  input  logic                    _reset,
  input  logic                    capture,
  input  logic                    prune_head,
  input  logic [16*2*width-1:0]   res1_flat,
  input  logic [16*2*width-1:0]   res2_flat,
  sa_result_drain_if.master       out_if,
  output logic                    busy,
  output logic                    done,
  output logic                    skipped,
  output logic                    overrun
);

  import sa_result_drain_pkg::*;

  state_e                  state_q, state_d;
  logic [2:0]              beat_q, beat_d;
  logic [16*2*width-1:0]   res1_q, res2_q;
  logic                    skipped_q, overrun_q;
  logic [4*2*width-1:0]    row_data;
  logic                    cap_ok;
  logic                    accept;
  logic                    last_beat;

  assign cap_ok    = capture && !prune_head && (state_q == StIdle);
  assign accept    = (state_q == StDrain) && out_if.out_ready;
  assign last_beat = (beat_q == 3'(BEATS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cap_ok) state_d = StDrain;
      StDrain: if (accept && last_beat) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Beat index returns to 0 after the final beat so mat/row idle at 0.
  always_comb begin
    beat_d = beat_q;
    if (cap_ok) begin
      beat_d = '0;
    end else if (accept) begin
      beat_d = last_beat ? 3'd0 : beat_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (_reset) begin
      beat_q    <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
      skipped_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      if (cap_ok) begin
        res1_q <= res1_flat;
        res2_q <= res2_flat;
      end
      skipped_q <= capture && prune_head && (state_q == StIdle);
      overrun_q <= overrun_q || (capture && (state_q != StIdle));
    end
  end

  sa_row_mux #(
    .width (width),
    .ROWS  (ROWS)
  ) u_row_mux (
    .res1_i (res1_q),
    .res2_i (res2_q),
    .mat_i  (beat_q[2]),
    .row_i  (beat_q[1:0]),
    .row_o  (row_data)
  );

  // Output logic
  always_comb begin
    out_if.out_valid = (state_q == StDrain);
    out_if.out_data  = out_if.out_valid ? row_data : '0;
    out_if.out_mat   = beat_q[2];
    out_if.out_row   = beat_q[1:0];
    out_if.out_last  = out_if.out_valid && last_beat;
    busy             = (state_q != StIdle);
    done             = (state_q == StFin);
    skipped          = skipped_q;
    overrun          = overrun_q;
  end

endmodule
